amp_i2c_arbiter: RTL
====================

# amp_i2c_arbiter

Arbitrates register-write requests from two requesters (boot sequencer, runtime volume/mute control) onto the single byte-write I2C engine that drives the Merus Gen1 amplifier. Tracks the amplifier's current register page and inserts a page-select write only when the page changes. Retries NACKed transfers a bounded number of times, enforces bus-free time between transfers and reports completion and error per request.

## Interface
Parameters:
- PAGE_REG, 7'h00: amp register address that holds the page select.
- MAX_RETRY, 2: retries after a NACK before giving up (total attempts = MAX_RETRY+1).
- GAP_CYC, 8: idle clk cycles enforced after every engine transfer; must be ≥1.

Ports:
- clk  in  1  system clock
- resetb  in  1  reset, synchronous, active-low
- req_valid  in  2  per-requester request; index 0 = boot, 1 = runtime; held until matching ack
- req0_page / req1_page  in  6 each  target page
- req0_addr / req1_addr  in  7 each  register address within page
- req0_data / req1_data  in  8 each  write data
- req_ack  out  2  one-cycle completion pulse per requester
- req_err  out  1  valid with any req_ack bit; 1 = retries exhausted
- eng_start  out  1  one-cycle pulse launching an engine write
- eng_addr  out  7  register address to engine; stable from eng_start until eng_done
- eng_data  out  8  data to engine; stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse, transfer finished
- eng_nack  in  1  sampled with eng_done; 1 = slave NACK
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PAGE_ISSUE, PAGE_WAIT, WR_ISSUE, WR_WAIT, GAP, DONE.
- IDLE: if any req_valid, grant round-robin: grant the requester not granted last; if only one valid, grant it. Last-grant pointer resets to 1, so first contention goes to requester 0. Latch page/addr/data of the granted requester into internal registers; later input changes are ignored until ack.
- After grant: if page cache valid and equal to latched page -> WR_ISSUE, else -> PAGE_ISSUE.
- PAGE_ISSUE: eng_start=1, eng_addr=PAGE_REG, eng_data={2'b00,page}; -> PAGE_WAIT.
- PAGE_WAIT: on eng_done: ACK -> update cache (valid, page), clear retry count, -> GAP then WR_ISSUE; NACK -> if retry count < MAX_RETRY increment, -> GAP then PAGE_ISSUE; else invalidate cache, set error, -> DONE.
- WR_ISSUE: eng_start=1, eng_addr=addr, eng_data=data; -> WR_WAIT.
- WR_WAIT: on eng_done: ACK -> clear error, -> GAP then DONE; NACK -> retry as above (re-enter WR_ISSUE via GAP), exhaustion -> set error, -> DONE (cache kept).
- GAP: counts GAP_CYC cycles with eng_start low, then proceeds to the recorded next state.
- DONE: req_ack[granted]=1, req_err=error for one cycle; clear retry count; -> IDLE.
- Retry counter is shared between page and data phases but cleared when page phase succeeds; width ceil(log2(MAX_RETRY+1)), no wrap.
- eng_done outside PAGE_WAIT/WR_WAIT is ignored.

## Timing
- Reset (resetb low at clk edge): state IDLE, eng_start=0, eng_addr=0, eng_data=0, req_ack=0, req_err=0, busy=0, page cache invalid, retry=0, last-grant=1. Reset mid-transfer aborts with no ack; the engine is reset by the same resetb.
- Grant: request seen in IDLE at edge N -> eng_start high cycle N+1 (PAGE_ISSUE or WR_ISSUE), busy high from N+1.
- Cache hit, ACK: eng_done at cycle D -> GAP cycles D+1..D+GAP_CYC -> req_ack at D+GAP_CYC+1.
- Page miss adds one full engine transfer plus GAP_CYC+1 cycles before the data eng_start.
- req_ack then IDLE: a still-asserted req_valid of the acked requester in the cycle after ack is treated as a new request; requesters must drop valid on ack.
- eng_done and a new req_valid in the same cycle: no effect on arbitration until IDLE.

## Test plan
- Single request 0 (page 3, addr 0x40, data 0x18) after reset, engine ACKs -> engine sees write 0x00<=0x03 then 0x40<=0x18, one req_ack[0], req_err=0.
- Second request 1 same page 3 (addr 0x35, data 0x08) -> single engine write only, ack latency from eng_done = GAP_CYC+1.
- Both valid simultaneously, repeated -> grants alternate 0,1,0,1; no requester acked twice in a row while other waits.
- Data write NACKed 2×, then ACKed (MAX_RETRY=2) -> 3 data starts, req_err=0; NACK 3× -> 3 starts, req_err=1, cache remains valid (next same-page request skips page write).
- Page write NACKed 3× -> req_err=1, no data write issued, next request re-issues page write.
- resetb low during WR_WAIT -> no ack, all outputs at reset values next cycle, next request re-issues page write.

Source files
------------

// File: rtl/amp_i2c_arbiter.sv
// amp_i2c_arbiter: round-robin arbiter of two register-write requesters onto a byte-write I2C engine, with page caching, NACK retry and bus-free gap.
module amp_i2c_arbiter #(
  parameter logic [6:0] PAGE_REG = 7'h00,
  parameter int MAX_RETRY = 2,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [1:0] req_valid,
  input  logic [5:0] req0_page,
  input  logic [5:0] req1_page,
  input  logic [6:0] req0_addr,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic [1:0] req_ack,
  output logic       req_err,
  output logic       eng_start,
  output logic [6:0] eng_addr,
  output logic [7:0] eng_data,
  input  logic       eng_done,
  input  logic       eng_nack,
  output logic       busy
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, PAGE_ISSUE, PAGE_WAIT, WR_ISSUE, WR_WAIT, GAP, DONE} state_t;
  state_t state, gap_next;
  logic [RW-1:0] retry;
  logic [GW-1:0] gap_cnt;
  logic cache_vld, grant, last_grant, err, g, hit, can_retry;
  logic [5:0] cache_page, lpage, gpage;
  logic [6:0] laddr, gaddr;
  logic [7:0] ldata, gdata;
  logic [1:0] ack_vec;
  always_comb begin
    g = &req_valid ? ~last_grant : req_valid[1];
    gpage = g ? req1_page : req0_page;
    gaddr = g ? req1_addr : req0_addr;
    gdata = g ? req1_data : req0_data;
    hit = cache_vld && cache_page == gpage;
    can_retry = retry < RW'(MAX_RETRY);
    ack_vec = grant ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= IDLE;
      gap_next <= IDLE;
      retry <= '0;
      gap_cnt <= '0;
      cache_vld <= 1'b0;
      cache_page <= '0;
      grant <= 1'b0;
      last_grant <= 1'b1;
      err <= 1'b0;
      lpage <= '0;
      laddr <= '0;
      ldata <= '0;
      req_ack <= '0;
      req_err <= 1'b0;
      eng_start <= 1'b0;
      eng_addr <= '0;
      eng_data <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant <= g;
          last_grant <= g;
          lpage <= gpage;
          laddr <= gaddr;
          ldata <= gdata;
          err <= 1'b0;
          busy <= 1'b1;
          eng_start <= 1'b1;
          state <= hit ? WR_ISSUE : PAGE_ISSUE;
          eng_addr <= hit ? gaddr : PAGE_REG;
          eng_data <= hit ? gdata : {2'b00, gpage};
        end
        PAGE_ISSUE: begin
          eng_start <= 1'b0;
          state <= PAGE_WAIT;
        end
        WR_ISSUE: begin
          eng_start <= 1'b0;
          state <= WR_WAIT;
        end
        PAGE_WAIT: if (eng_done) begin
          gap_cnt <= '0;
          if (!eng_nack) begin
            cache_vld <= 1'b1;
            cache_page <= lpage;
            retry <= '0;
            state <= GAP;
            gap_next <= WR_ISSUE;
          end else if (can_retry) begin
            retry <= retry + 1'b1;
            state <= GAP;
            gap_next <= PAGE_ISSUE;
          end else begin
            cache_vld <= 1'b0;
            err <= 1'b1;
            state <= DONE;
            req_ack <= ack_vec;
            req_err <= 1'b1;
          end
        end
        WR_WAIT: if (eng_done) begin
          gap_cnt <= '0;
          if (!eng_nack) begin
            err <= 1'b0;
            state <= GAP;
            gap_next <= DONE;
          end else if (can_retry) begin
            retry <= retry + 1'b1;
            state <= GAP;
            gap_next <= WR_ISSUE;
          end else begin
            err <= 1'b1;
            state <= DONE;
            req_ack <= ack_vec;
            req_err <= 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state <= gap_next;
            req_ack <= gap_next == DONE ? ack_vec : 2'b00;
            req_err <= gap_next == DONE && err;
            eng_start <= gap_next != DONE;
            eng_addr <= gap_next == PAGE_ISSUE ? PAGE_REG : laddr;
            eng_data <= gap_next == PAGE_ISSUE ? {2'b00, lpage} : ldata;
          end
        end
        DONE: begin
          req_ack <= '0;
          req_err <= 1'b0;
          retry <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
